// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared FSM encoding, alignment mask and M/W register payload.
package mem_access_stage_pkg;
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b00;
  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        upper;
    logic [31:0] alu_result;
    logic [4:0]  write_reg;
  } mw_t;
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: ready/valid data-memory bus between the M stage and data memory.
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master(output req, we, addr, wdata, input ready, rdata);
  modport slave(input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_access_stage_pipeline_mw_reg.sv
// pipeline_mw_reg: M/W pipeline register; hold inserts a bubble, kill retires the instruction as a bubble.
module pipeline_mw_reg
  import mem_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        kill,
  input  logic        load,
  input  mw_t         d,
  input  logic [31:0] rdata,
  output mw_t         q,
  output logic [31:0] read_data
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q         <= '0;
      read_data <= '0;
    end else begin
      if (hold) begin
        q.reg_write  <= 1'b0;
        q.mem_to_reg <= 1'b0;
      end else
        q <= '{reg_write: d.reg_write & ~kill, mem_to_reg: d.mem_to_reg & ~kill,
               upper: d.upper, alu_result: d.alu_result, write_reg: d.write_reg};
      if (load) read_data <= rdata;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: M stage with variable-latency data-memory access, stall/timeout FSM and M/W register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       reg_write_m,
  input  logic                       mem_to_reg_m,
  input  logic                       mem_write_m,
  input  logic                       upper_m,
  input  logic [31:0]                alu_result_m,
  input  logic [31:0]                write_data_m,
  input  logic [4:0]                 write_reg_m,
  mem_access_stage_if.master         dmem,
  output logic                       stall_m,
  output logic                       addr_error_m,
  output logic                       bus_error_m,
  output logic                       reg_write_w,
  output logic                       mem_to_reg_w,
  output logic                       upper_w,
  output logic [31:0]                read_data_w,
  output logic [31:0]                alu_result_w,
  output logic [4:0]                 write_reg_w
);
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             access, misaligned, timeout, load_done;
  mw_t              mw_q;
  assign access     = mem_to_reg_m | mem_write_m;
  assign misaligned = access & (alu_result_m[1:0] != WORD_ALIGN_MASK);
  assign dmem.we    = mem_write_m;
  assign dmem.addr  = alu_result_m;
  assign dmem.wdata = write_data_m;
  // Outputs are gated by reset so the request drops the moment reset rises, not at the next edge.
  always_comb begin
    dmem.req     = ~reset & ((state == S_WAIT) | (access & ~misaligned));
    addr_error_m = ~reset & misaligned & (state == S_IDLE);
    timeout      = dmem.req & ~dmem.ready & (state == S_WAIT) & (cnt == CNT_W'(TIMEOUT));
    bus_error_m  = timeout;
    stall_m      = dmem.req & ~dmem.ready & ~timeout;
    load_done    = dmem.req & dmem.ready & ~dmem.we;
    state_nx     = stall_m ? S_WAIT : S_IDLE;
    cnt_nx       = stall_m ? cnt + CNT_W'(1) : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  pipeline_mw_reg u_mw (
    .clk      (clk),
    .reset    (reset),
    .hold     (stall_m),
    .kill     (misaligned | timeout),
    .load     (load_done),
    .d        ('{reg_write: reg_write_m, mem_to_reg: mem_to_reg_m, upper: upper_m,
                 alu_result: alu_result_m, write_reg: write_reg_m}),
    .rdata    (dmem.rdata),
    .q        (mw_q),
    .read_data(read_data_w)
  );
  assign reg_write_w  = mw_q.reg_write;
  assign mem_to_reg_w = mw_q.mem_to_reg;
  assign upper_w      = mw_q.upper;
  assign alu_result_w = mw_q.alu_result;
  assign write_reg_w  = mw_q.write_reg;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: vector table, randomized instruction stream and reset corner case for mem_access_stage.
module tb_mem_access_stage;
  localparam int T = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic reg_write_m = 0, mem_to_reg_m = 0, mem_write_m = 0, upper_m = 0;
  logic [31:0] alu_result_m = '0, write_data_m = '0;
  logic [4:0] write_reg_m = '0;
  logic stall_m, addr_error_m, bus_error_m, reg_write_w, mem_to_reg_w, upper_w;
  logic [31:0] read_data_w, alu_result_w;
  logic [4:0] write_reg_w;
  int checks = 0, errors = 0;
  logic [31:0] exp_rd_w = '0;
  mem_access_stage_if bus();
  mem_access_stage #(.TIMEOUT(T), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
    .mem_write_m(mem_write_m), .upper_m(upper_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .write_reg_m(write_reg_m), .dmem(bus),
    .stall_m(stall_m), .addr_error_m(addr_error_m), .bus_error_m(bus_error_m),
    .reg_write_w(reg_write_w), .mem_to_reg_w(mem_to_reg_w), .upper_w(upper_w),
    .read_data_w(read_data_w), .alu_result_w(alu_result_w), .write_reg_w(write_reg_w));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: a memory that is not ready for lat cycles stalls min(lat,T) cycles,
  // and aborts with a bus error if lat exceeds T. Called at a falling edge, returns at a falling edge.
  task automatic run_instr(input logic ld, input logic st, input logic rw, input logic up,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                           input logic [4:0] wr, input int lat,
                           output int n_stall, output logic aerr, output logic berr);
    logic acc, mis, go, to, kill;
    int stalls;
    acc = ld | st;
    mis = acc && addr[1:0] != 2'b00;
    go = acc && !mis;
    stalls = go ? (lat < T ? lat : T) : 0;
    to = go && lat > T;
    kill = mis || to;
    n_stall = 0; aerr = 0; berr = 0;
    mem_to_reg_m = ld; mem_write_m = st; reg_write_m = rw; upper_m = up;
    alu_result_m = addr; write_data_m = wd; write_reg_m = wr; bus.rdata = rd;
    for (int k = 0; k <= stalls; k++) begin
      bus.ready = go && k == lat;
      #1;
      chk("dmem_req", bus.req, go);
      if (go) begin
        chk("dmem_addr", bus.addr, addr);
        chk("dmem_we", bus.we, st);
        if (st) chk("dmem_wdata", bus.wdata, wd);
      end
      chk("stall_m", stall_m, k < stalls);
      chk("addr_error_m", addr_error_m, mis);
      chk("bus_error_m", bus_error_m, to && k == T);
      n_stall += int'(stall_m);
      aerr |= addr_error_m;
      berr |= bus_error_m;
      @(posedge clk); #1;
      if (k < stalls) begin
        chk("bubble reg_write_w", reg_write_w, 1'b0);
        chk("bubble mem_to_reg_w", mem_to_reg_w, 1'b0);
      end else begin
        if (ld && go && !to) exp_rd_w = rd;
        chk("reg_write_w", reg_write_w, rw && !kill);
        chk("mem_to_reg_w", mem_to_reg_w, ld && !kill);
        chk("read_data_w", read_data_w, exp_rd_w);
        if (!kill) begin
          chk("upper_w", upper_w, up);
          chk("alu_result_w", alu_result_w, addr);
          chk("write_reg_w", write_reg_w, wr);
        end
      end
      @(negedge clk);
    end
    bus.ready = 0;
  endtask

  typedef struct {
    logic ld, st, rw, up;
    logic [31:0] addr, wd, rd;
    logic [4:0] wr;
    int lat;
    int e_stall;
    logic e_aerr, e_berr, e_rw, e_m2r;
    logic [31:0] e_rd;
  } vec_t;

  initial begin
    vec_t v[8];
    int ns;
    logic ae, be;
    bus.ready = 0; bus.rdata = '0;
    v[0] = '{1,0,1,0,32'h100,32'h0,32'hDEADBEEF,5'd5,0, 0,0,0,1,1,32'hDEADBEEF};
    v[1] = '{1,0,1,1,32'h104,32'h0,32'hCAFEF00D,5'd7,3, 3,0,0,1,1,32'hCAFEF00D};
    v[2] = '{0,1,0,0,32'h20,32'h12345678,32'h0,5'd0,1, 1,0,0,0,0,32'hCAFEF00D};
    v[3] = '{1,0,1,0,32'h102,32'h0,32'h55555555,5'd9,0, 0,1,0,0,0,32'hCAFEF00D};
    v[4] = '{1,0,1,0,32'h200,32'h0,32'h66666666,5'd4,9, 4,0,1,0,0,32'hCAFEF00D};
    v[5] = '{0,0,1,1,32'h7,32'h0,32'h0,5'd3,0, 0,0,0,1,0,32'hCAFEF00D};
    v[6] = '{1,0,1,0,32'h300,32'h0,32'h0BADC0DE,5'd11,4, 4,0,0,1,1,32'h0BADC0DE};
    v[7] = '{0,1,0,0,32'h21,32'hAAAA5555,32'h0,5'd0,0, 0,1,0,0,0,32'h0BADC0DE};
    @(negedge clk); @(negedge clk);
    chk("reset dmem_req", bus.req, 1'b0);
    chk("reset stall_m", stall_m, 1'b0);
    chk("reset reg_write_w", reg_write_w, 1'b0);
    chk("reset read_data_w", read_data_w, 32'h0);
    chk("reset alu_result_w", alu_result_w, 32'h0);
    reset = 0;
    @(negedge clk);
    foreach (v[i]) begin
      run_instr(v[i].ld, v[i].st, v[i].rw, v[i].up, v[i].addr, v[i].wd, v[i].rd, v[i].wr, v[i].lat, ns, ae, be);
      chk($sformatf("vec%0d stall cycles", i), ns, v[i].e_stall);
      chk($sformatf("vec%0d addr_error", i), ae, v[i].e_aerr);
      chk($sformatf("vec%0d bus_error", i), be, v[i].e_berr);
      chk($sformatf("vec%0d reg_write_w", i), reg_write_w, v[i].e_rw);
      chk($sformatf("vec%0d mem_to_reg_w", i), mem_to_reg_w, v[i].e_m2r);
      chk($sformatf("vec%0d read_data_w", i), read_data_w, v[i].e_rd);
    end
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_instr(kind == 1, kind == 2, $urandom_range(0, 1) == 1 && kind != 2, $urandom_range(0, 1) == 1,
                a, $urandom, $urandom, 5'($urandom), $urandom_range(0, 6), ns, ae, be);
    end
    // Reset in the second WAIT cycle of a load that never gets ready.
    mem_to_reg_m = 1; mem_write_m = 0; reg_write_m = 1; alu_result_m = 32'h400; write_reg_m = 5'd2;
    bus.ready = 0;
    #1 chk("pre-reset stall", stall_m, 1'b1);
    @(negedge clk); @(negedge clk);
    #1 chk("2nd wait stall", stall_m, 1'b1);
    reset = 1;
    #1;
    chk("async dmem_req", bus.req, 1'b0);
    chk("async stall_m", stall_m, 1'b0);
    chk("async reg_write_w", reg_write_w, 1'b0);
    chk("async read_data_w", read_data_w, 32'h0);
    chk("async alu_result_w", alu_result_w, 32'h0);
    chk("async write_reg_w", write_reg_w, 32'h0);
    exp_rd_w = '0;
    @(negedge clk);
    mem_to_reg_m = 0; reg_write_m = 0;
    reset = 0;
    @(negedge clk);
    run_instr(1, 0, 1, 0, 32'h500, 32'h0, 32'h13579BDF, 5'd6, 0, ns, ae, be);
    chk("post-reset stall cycles", ns, 0);
    chk("post-reset read_data_w", read_data_w, 32'h13579BDF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
